// File: rtl/cnn_pkg.sv
// Shared types and geometry helpers for the convolution feature-map server.
package cnn_pkg;

   localparam int DATA_WIDTH_DEF        = 27;
   localparam int FRACTION_WIDTH_DEF    = 8;
   localparam int ADDR_WIDTH_DEF        = 10;
   localparam int CONV_LAYER_WIDTH_DEF  = 12;
   localparam int CONV_LAYER_HEIGHT_DEF = 12;
   localparam int CHANNEL_NUM_DEF       = 2;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      LOADING = 2'd1,
      READY   = 2'd2
   } srv_state_e;

   function automatic int calc_depth(input int width, input int height, input int channels);
      return width * height * channels;
   endfunction

endpackage

// File: rtl/conv_data_ram.sv
// Simple dual-port feature-map store: one write port, one registered read port.
module conv_data_ram #(
   parameter int DATA_WIDTH = 27,
   parameter int ADDR_WIDTH = 10,
   parameter int DEPTH      = 288
) (
   input  logic                  clk,
   input  logic                  wr_en,
   input  logic [ADDR_WIDTH-1:0] wr_addr,
   input  logic [DATA_WIDTH-1:0] wr_data,
   input  logic                  rd_en,
   input  logic [ADDR_WIDTH-1:0] rd_addr,
   output logic [DATA_WIDTH-1:0] rd_data
);

   logic [DATA_WIDTH-1:0] mem [DEPTH];
   logic [DATA_WIDTH-1:0] rd_data_q;

   // No reset on the array or read register; the server gates the response.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_addr] <= wr_data;
      end
      if (rd_en) begin
         rd_data_q <= mem[rd_addr];
      end
   end

   assign rd_data = rd_data_q;

endmodule

// File: rtl/conv_data_server.sv
// Holds one convolution layer: streams it in, then serves 1-cycle reads until released.
module conv_data_server
   import cnn_pkg::*;
#(
   parameter int DATA_WIDTH        = DATA_WIDTH_DEF,
   parameter int FRACTION_WIDTH    = FRACTION_WIDTH_DEF,
   parameter int ADDR_WIDTH        = ADDR_WIDTH_DEF,
   parameter int CONV_LAYER_WIDTH  = CONV_LAYER_WIDTH_DEF,
   parameter int CONV_LAYER_HEIGHT = CONV_LAYER_HEIGHT_DEF,
   parameter int CHANNEL_NUM       = CHANNEL_NUM_DEF
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  load_valid,
   input  logic [DATA_WIDTH-1:0] load_data,
   output logic                  load_ready,
   input  logic                  layer_release,
   output logic                  layer_ready,
   input  logic                  read_en,
   input  logic [ADDR_WIDTH-1:0] read_address,
   output logic [DATA_WIDTH-1:0] conv_data,
   output logic                  conv_data_valid,
   output logic                  read_error
);

   // state   | meaning
   // IDLE    | no layer held, waiting for the first load word
   // LOADING | layer partially written, counter holds next write address
   // READY   | full layer resident, reads are served

   localparam int DEPTH = calc_depth(CONV_LAYER_WIDTH, CONV_LAYER_HEIGHT, CHANNEL_NUM);
   localparam int CNT_W = $clog2(DEPTH + 1);
   localparam logic [CNT_W-1:0]    CNT_LAST   = CNT_W'(DEPTH - 1);
   localparam logic [CNT_W-1:0]    CNT_FULL   = CNT_W'(DEPTH);
   localparam logic [ADDR_WIDTH:0] ADDR_LIMIT = (ADDR_WIDTH + 1)'(DEPTH);

   generate
      if (DEPTH > 2 ** ADDR_WIDTH) begin : g_depth_chk
         $error("conv_data_server: layer depth exceeds read address range");
      end
      if (FRACTION_WIDTH < 0 || FRACTION_WIDTH >= DATA_WIDTH) begin : g_frac_chk
         $error("conv_data_server: fraction width out of range");
      end
   endgenerate

   srv_state_e             state_q, state_d;
   logic [CNT_W-1:0]       cnt_q, cnt_d;
   logic                   layer_ready_q, layer_ready_d;
   logic                   valid_q, valid_d;
   logic                   err_q, err_d;
   logic                   load_accept;
   logic                   rd_hit;
   logic [DATA_WIDTH-1:0]  ram_rd_data;

   // Counter saturating at DEPTH also blocks loads, independent of state.
   assign load_ready  = (state_q != READY) && (cnt_q != CNT_FULL);
   assign load_accept = load_valid && load_ready;
   assign rd_hit      = read_en && (state_q == READY) && ({1'b0, read_address} < ADDR_LIMIT);

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         IDLE, LOADING: begin
            if (load_accept) begin
               cnt_d   = cnt_q + 1'b1;
               state_d = (cnt_q == CNT_LAST) ? READY : LOADING;
            end
         end
         READY: begin
            if (layer_release) begin
               state_d = IDLE;
               cnt_d   = '0;
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      endcase
      layer_ready_d = (state_d == READY);
      valid_d       = rd_hit;
      err_d         = read_en && !rd_hit;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q       <= IDLE;
         cnt_q         <= '0;
         layer_ready_q <= 1'b0;
         valid_q       <= 1'b0;
         err_q         <= 1'b0;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         layer_ready_q <= layer_ready_d;
         valid_q       <= valid_d;
         err_q         <= err_d;
      end
   end

   conv_data_ram #(
      .DATA_WIDTH (DATA_WIDTH),
      .ADDR_WIDTH (ADDR_WIDTH),
      .DEPTH      (DEPTH)
   ) u_ram (
      .clk     (clk),
      .wr_en   (load_accept),
      .wr_addr (ADDR_WIDTH'(cnt_q)),
      .wr_data (load_data),
      .rd_en   (rd_hit),
      .rd_addr (read_address),
      .rd_data (ram_rd_data)
   );

   assign layer_ready     = layer_ready_q;
   assign conv_data_valid = valid_q;
   assign read_error      = err_q;
   assign conv_data       = valid_q ? ram_rd_data : '0;

endmodule

// File: tb/tb_conv_data_server.sv
// Scoreboard bench: stimulus pushes expected read responses, a monitor pops and compares.
module tb_conv_data_server;

   localparam int DW    = 27;
   localparam int AW    = 10;
   localparam int DEPTH = 12 * 12 * 2;

   typedef struct {
      logic          valid;
      logic          err;
      logic [DW-1:0] data;
   } exp_t;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          load_valid = 1'b0;
   logic [DW-1:0] load_data = '0;
   logic          load_ready;
   logic          layer_release = 1'b0;
   logic          layer_ready;
   logic          read_en = 1'b0;
   logic [AW-1:0] read_address = '0;
   logic [DW-1:0] conv_data;
   logic          conv_data_valid;
   logic          read_error;

   conv_data_server dut (
      .clk             (clk),
      .reset           (reset),
      .load_valid      (load_valid),
      .load_data       (load_data),
      .load_ready      (load_ready),
      .layer_release   (layer_release),
      .layer_ready     (layer_ready),
      .read_en         (read_en),
      .read_address    (read_address),
      .conv_data       (conv_data),
      .conv_data_valid (conv_data_valid),
      .read_error      (read_error)
   );

   always #5 clk = ~clk;

   // Reference model: the layer as an array plus "how many words held" and "resident".
   logic [DW-1:0] model_mem [DEPTH];
   int            loaded = 0;
   logic          resident = 1'b0;
   exp_t          exp_q [$];
   int            n_cmp = 0;
   int            n_bad = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      n_cmp++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d at %0t", name, act, req, $time);
      end
   endtask

   always @(negedge clk) begin
      if (!reset) begin
         if (conv_data_valid || read_error) begin
            if (exp_q.size() == 0) begin
               n_cmp++;
               n_bad++;
               $display("FAIL unexpected_response: valid=%0b err=%0b data=%0d, none expected",
                        conv_data_valid, read_error, conv_data);
            end else begin
               exp_t e;
               e = exp_q.pop_front();
               chk("rsp_valid", 32'(conv_data_valid), 32'(e.valid));
               chk("rsp_error", 32'(read_error), 32'(e.err));
               chk("rsp_data", 32'(conv_data), 32'(e.data));
            end
         end else begin
            chk("idle_data_zero", 32'(conv_data), 32'd0);
         end
      end
   end

   // One clock of stimulus, entered 1 time unit after a rising edge.
   task automatic step(input logic lv, input logic [DW-1:0] ld, input logic re,
                       input logic [AW-1:0] ra, input logic rel);
      exp_t e;
      logic accept;
      chk("load_ready", 32'(load_ready), 32'(!resident && loaded < DEPTH));
      chk("layer_ready", 32'(layer_ready), 32'(resident));
      load_valid    = lv;
      load_data     = ld;
      read_en       = re;
      read_address  = ra;
      layer_release = rel;
      if (re) begin
         e.valid = resident && (int'(ra) < DEPTH);
         e.err   = !e.valid;
         e.data  = e.valid ? model_mem[int'(ra)] : '0;
         exp_q.push_back(e);
      end
      accept = lv && !resident && loaded < DEPTH;
      @(posedge clk);
      #1;
      if (accept) begin
         model_mem[loaded] = ld;
         loaded++;
         if (loaded == DEPTH) resident = 1'b1;
      end else if (rel && resident) begin
         resident = 1'b0;
         loaded   = 0;
      end
      load_valid    = 1'b0;
      read_en       = 1'b0;
      layer_release = 1'b0;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      exp_q.delete();
      resident = 1'b0;
      loaded   = 0;
      #1;
      chk("rst_layer_ready", 32'(layer_ready), 32'd0);
      chk("rst_valid", 32'(conv_data_valid), 32'd0);
      chk("rst_error", 32'(read_error), 32'd0);
      chk("rst_data", 32'(conv_data), 32'd0);
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      chk("post_rst_load_ready", 32'(load_ready), 32'd1);
   endtask

   function automatic logic [AW-1:0] rand_addr();
      if ($urandom_range(0, 3) == 0) return AW'($urandom_range(DEPTH, 1023));
      return AW'($urandom_range(0, DEPTH - 1));
   endfunction

   initial begin
      int guard;
      #2;
      do_reset();

      // Sequential load 1..DEPTH; a read at word 50 must error without disturbing the load.
      for (int i = 0; i < DEPTH; i++) begin
         step(1'b1, DW'(i + 1), (i == 49), AW'(5), 1'b0);
      end
      for (int i = 0; i < 3; i++) step(1'b1, DW'(9999), 1'b0, '0, 1'b0);

      step(1'b0, '0, 1'b1, AW'(0), 1'b0);
      step(1'b0, '0, 1'b1, AW'(143), 1'b0);
      step(1'b0, '0, 1'b1, AW'(287), 1'b0);
      step(1'b0, '0, 1'b1, AW'(288), 1'b0);
      step(1'b0, '0, 1'b1, AW'(1023), 1'b0);
      for (int i = 0; i < 40; i++) begin
         step(1'b0, '0, 1'($urandom_range(0, 1)), rand_addr(), 1'b0);
      end

      // Release with a same-cycle read, then a read the next cycle.
      step(1'b0, '0, 1'b1, AW'(10), 1'b1);
      step(1'b0, '0, 1'b1, AW'(10), 1'b0);
      step(1'b0, '0, 1'b0, '0, 1'b1);

      // Random data with gaps and interleaved reads and stray releases.
      guard = 0;
      while (!resident && guard < 3000) begin
         step(1'($urandom_range(0, 3) != 0), DW'($urandom), 1'($urandom_range(0, 1)),
              rand_addr(), 1'($urandom_range(0, 7) == 0));
         guard++;
      end
      chk("random_load_done", 32'(resident), 32'd1);
      for (int i = 0; i < 60; i++) begin
         step(1'($urandom_range(0, 1)), DW'($urandom), 1'($urandom_range(0, 3) != 0),
              rand_addr(), 1'b0);
      end

      // Abandon a partial layer with reset, then reload 500..787.
      step(1'b0, '0, 1'b0, '0, 1'b1);
      for (int i = 0; i < 100; i++) step(1'b1, DW'(i + 7), 1'b0, '0, 1'b0);
      do_reset();
      for (int i = 0; i < DEPTH; i++) step(1'b1, DW'(500 + i), 1'b0, '0, 1'b0);
      step(1'b0, '0, 1'b1, AW'(0), 1'b0);
      step(1'b0, '0, 1'b1, AW'(287), 1'b0);
      for (int i = 0; i < 20; i++) step(1'b0, '0, 1'b1, rand_addr(), 1'b0);

      // A read in flight when reset hits must never appear.
      step(1'b0, '0, 1'b1, AW'(3), 1'b0);
      do_reset();
      for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b0, '0, 1'b0);

      chk("queue_drained", 32'(exp_q.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/conv_data_server.md
CONV_DATA_SERVER -- requirements
Module: conv_data_server

Interface
REQ-001 Parameter DATA_WIDTH, default 27, is the feature-map word width (signed fixed point).
REQ-002 Parameter FRACTION_WIDTH, default 8, is the fraction bits; carried through to the package only, with no arithmetic in this block.
REQ-003 Parameter ADDR_WIDTH, default 10, is the read-address width.
REQ-004 Parameters CONV_LAYER_WIDTH, CONV_LAYER_HEIGHT and CHANNEL_NUM, defaults 12, 12 and 2, are the layer geometry; DEPTH = W*H*C (288) SHALL be ≤ 2**ADDR_WIDTH, checked at elaboration.
REQ-005 clk  in  1  sole clock; all state on rising edge.
REQ-006 reset  in  1  asynchronous, active-high reset.
REQ-007 load_valid  in  1  producer has a load word.
REQ-008 load_data  in  DATA_WIDTH  load word, order channel-major, then row, then column.
REQ-009 load_ready  out  1  block accepts a load word.
REQ-010 release  in  1  single-cycle pulse: consumer finished with the layer.
REQ-011 layer_ready  out  1  full layer resident; reads are served.
REQ-012 read_en  in  1  read request from the convolution engine.
REQ-013 read_address  in  ADDR_WIDTH  linear word address (c*W*H + r*W + col).
REQ-014 conv_data  out  DATA_WIDTH  read response word.
REQ-015 conv_data_valid  out  1  conv_data is valid this cycle.
REQ-016 read_error  out  1  the request answered this cycle was illegal.

Function
REQ-017 The FSM SHALL have three states: IDLE, LOADING and READY.
REQ-018 IDLE SHALL go to LOADING on the first accepted word (load_valid && load_ready).
REQ-019 In LOADING, a load counter SHALL go 0..DEPTH-1; the word accepted at DEPTH-1 SHALL move the FSM to READY on the next edge.
REQ-020 READY SHALL go to IDLE on release; release in IDLE or LOADING SHALL be ignored.
REQ-021 load_ready SHALL be 1 in IDLE and LOADING and 0 in READY; the counter SHALL clear on entering IDLE.
REQ-022 The load counter SHALL never wrap: on reaching DEPTH the block SHALL stop accepting words (load_ready=0).
REQ-023 layer_ready SHALL equal (state==READY), registered.
REQ-024 Read latency SHALL be exactly 1 cycle: a request at edge N produces conv_data, conv_data_valid and read_error during cycle N+1.
REQ-025 Reads SHALL be fully pipelined, one accepted per cycle, with no backpressure.
REQ-026 conv_data_valid SHALL be 1 one cycle after read_en when layer_ready=1 and read_address < DEPTH.
REQ-027 A read_en with layer_ready=0 or read_address ≥ DEPTH SHALL give read_error=1, conv_data_valid=0 and conv_data=0 one cycle later.
REQ-028 conv_data SHALL be forced to 0 whenever conv_data_valid=0.
REQ-029 A read request in the same cycle as release SHALL still be served, since the state is sampled before the edge.
REQ-030 A read in the cycle after release SHALL give read_error.
REQ-031 The stored word SHALL be returned bit-exact; the block performs no arithmetic.

Reset
REQ-032 reset SHALL force the FSM to IDLE, the load counter to 0, layer_ready=0, conv_data=0, conv_data_valid=0 and read_error=0, with load_ready=1 in the first cycle after reset deasserts.
REQ-033 Reset asserted mid-LOADING or mid-READY SHALL abandon the layer; storage contents are don't-care and are not cleared.
REQ-034 An in-flight read response SHALL be suppressed by reset.

Structure
REQ-035 Package cnn_pkg SHALL hold the FSM state enum (IDLE, LOADING, READY) and a localparam function computing DEPTH from the geometry.
REQ-036 Storage SHALL be one sub-module, conv_data_ram: simple dual-port, 1 write and 1 synchronous read port, DEPTH x DATA_WIDTH, no reset on the array.
REQ-037 FSM, counter and response gating SHALL live in conv_data_server.

Verification
REQ-038 Reset, then stream values 1..288 with load_valid held at 1 -> layer_ready rises the cycle after word 288 is accepted; load_ready=0 from then on.
REQ-039 READY, then read addresses 0, 143 and 287 back-to-back -> conv_data 1, 144 and 288 on consecutive cycles, conv_data_valid=1 each cycle.
REQ-040 READY, then read address 288, then address 1023 -> read_error=1 and conv_data=0 on both responses.
REQ-041 Read address 5 during LOADING (word 50 of 288) -> read_error=1; the load proceeds unaffected.
REQ-042 release together with a read of address 10 -> conv_data=11 valid; a read the next cycle -> read_error=1; layer_ready=0 and load_ready=1.
REQ-043 Reset asserted after 100 loaded words, then a full reload of 500..787 -> address 0 reads 500 and address 287 reads 787.
